// File: rtl/dcache_controller.sv
// Purpose : sequences dcache_mem lookups, dirty-victim writebacks and refills for one load and one store port.
// Latency : hit grant->done 2 cycles; miss 3 cycles + bus latency (+ writeback and bus retries).
// Backpressure: one request in flight; grants only from IDLE, bus commands held until mem_response != 0.
//
// Ports:
//   clock, reset     system clock; synchronous active-low reset
//   ld_*             load request/grant handshake (req held until gnt), ld_done pulse with ld_data
//   st_*             store request/grant handshake (req held until gnt), st_done pulse
//   cache_*          probe/write controls to dcache_mem and its hit/miss/dirty/victim/rdata response
//   mem_*            shared memory bus: command + block address out, issue tag and return tag in
module dcache_controller #(
    parameter int ADDR_W    = 64,
    parameter int BLOCK_W   = 64,
    parameter int INDEX_W   = 5,
    parameter int MEM_TAG_W = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    // load port
    input  logic                            ld_req,
    input  logic [ADDR_W-1:0]               ld_addr,
    output logic                            ld_gnt,
    output logic                            ld_done,
    output logic [BLOCK_W-1:0]              ld_data,
    // store port
    input  logic                            st_req,
    input  logic [ADDR_W-1:0]               st_addr,
    input  logic [BLOCK_W-1:0]              st_data,
    output logic                            st_gnt,
    output logic                            st_done,
    // dcache_mem
    output logic [INDEX_W-1:0]              cache_index,
    output logic [ADDR_W-INDEX_W-4:0]       cache_tag,
    output logic                            cache_rd_en,
    output logic                            cache_wr_en,
    output logic [BLOCK_W-1:0]              cache_wr_data,
    input  logic                            cache_hit,
    input  logic                            cache_miss,
    input  logic                            cache_dirty,
    input  logic [ADDR_W-INDEX_W-4:0]       victim_tag,
    input  logic [BLOCK_W-1:0]              cache_rdata,
    // memory bus
    output logic [1:0]                      mem_command,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [MEM_TAG_W-1:0]            mem_response,
    input  logic [MEM_TAG_W-1:0]            mem_tag
);

    localparam int TAG_W = ADDR_W - INDEX_W - 3;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_REFILL,
        S_WAIT,
        S_RESP
    } state_t;

    // The accepted request: only the block address fields matter, the store
    // data goes straight into cache_wr_data at accept time.
    typedef struct packed {
        logic               is_store;
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
    } req_t;

    state_t               state;
    req_t                 req_q;
    req_t                 req_d;
    logic                 rr_is_ld;    // side that wins when both ports request
    logic [MEM_TAG_W-1:0] saved_tag;   // bus tag of the outstanding refill, 0 = none
    logic                 bus_accept;
    logic                 tag_match;

    // Block offset bits never take part in a lookup.
    logic unused_bits;
    assign unused_bits = ^{ld_addr[2:0], st_addr[2:0], cache_miss};

    // Grants are combinational so the requester sees gnt in the same cycle
    // the controller latches its address. Gated by reset so nothing is
    // accepted while reset is being applied.
    always_comb begin
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        if (reset && (state == S_IDLE)) begin
            if (ld_req && st_req) begin
                ld_gnt = rr_is_ld;
                st_gnt = !rr_is_ld;
            end else begin
                ld_gnt = ld_req;
                st_gnt = st_req;
            end
        end
    end

    always_comb begin
        req_d          = '0;
        req_d.is_store = st_gnt;
        if (st_gnt) begin
            req_d.tag   = st_addr[ADDR_W-1:INDEX_W+3];
            req_d.index = st_addr[INDEX_W+2:3];
        end else begin
            req_d.tag   = ld_addr[ADDR_W-1:INDEX_W+3];
            req_d.index = ld_addr[INDEX_W+2:3];
        end
    end

    assign bus_accept = (mem_response != '0);
    assign tag_match  = (saved_tag != '0) && (mem_tag == saved_tag);

    // dcache_mem output is registered, so its data lines up with the RESP
    // cycle; pass it through only while ld_done is high.
    assign ld_data = ld_done ? cache_rdata : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            req_q         <= '0;
            rr_is_ld      <= 1'b1;
            saved_tag     <= '0;
            ld_done       <= 1'b0;
            st_done       <= 1'b0;
            cache_index   <= '0;
            cache_tag     <= '0;
            cache_rd_en   <= 1'b0;
            cache_wr_en   <= 1'b0;
            cache_wr_data <= '0;
            mem_command   <= BUS_NONE;
            mem_addr      <= '0;
        end else begin
            ld_done <= 1'b0;
            st_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_gnt || st_gnt) begin
                        req_q <= req_d;
                        if (ld_req && st_req) begin
                            rr_is_ld <= !rr_is_ld;
                        end
                        cache_index   <= req_d.index;
                        cache_tag     <= req_d.tag;
                        cache_rd_en   <= ld_gnt;
                        cache_wr_en   <= st_gnt;
                        cache_wr_data <= st_gnt ? st_data : '0;
                        state         <= S_LOOKUP;
                    end
                end

                // Probe is a single cycle; anything that is not a hit is
                // handled as a miss, with the dirty flag picking writeback.
                S_LOOKUP: begin
                    cache_rd_en <= 1'b0;
                    cache_wr_en <= 1'b0;
                    if (cache_hit) begin
                        ld_done <= !req_q.is_store;
                        st_done <= req_q.is_store;
                        state   <= S_RESP;
                    end else if (cache_dirty) begin
                        mem_command <= BUS_STORE;
                        mem_addr    <= {victim_tag, req_q.index, 3'b000};
                        state       <= S_WB;
                    end else begin
                        mem_command <= BUS_LOAD;
                        mem_addr    <= {req_q.tag, req_q.index, 3'b000};
                        state       <= S_REFILL;
                    end
                end

                // Once the victim is on the bus, re-probe: the set is now
                // clean, so the second lookup goes to refill.
                S_WB: begin
                    if (bus_accept) begin
                        mem_command <= BUS_NONE;
                        mem_addr    <= '0;
                        cache_rd_en <= !req_q.is_store;
                        cache_wr_en <= req_q.is_store;
                        state       <= S_LOOKUP;
                    end
                end

                S_REFILL: begin
                    if (bus_accept) begin
                        saved_tag   <= mem_response;
                        mem_command <= BUS_NONE;
                        mem_addr    <= '0;
                        state       <= S_WAIT;
                    end
                end

                // Other transactions share the bus; only our own tag counts.
                S_WAIT: begin
                    if (tag_match) begin
                        saved_tag <= '0;
                        ld_done   <= !req_q.is_store;
                        st_done   <= req_q.is_store;
                        state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    cache_index   <= '0;
                    cache_tag     <= '0;
                    cache_wr_data <= '0;
                    req_q         <= '0;
                    state         <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // dcache_mem must never report hit and miss for the same probe.
    always_ff @(posedge clock) begin
        if (reset && (state == S_LOOKUP)) begin
            assert (!(cache_hit && cache_miss));
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

    localparam int ADDR_W    = 64;
    localparam int BLOCK_W   = 64;
    localparam int INDEX_W   = 5;
    localparam int MEM_TAG_W = 4;
    localparam int TAG_W     = ADDR_W - INDEX_W - 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 ld_req;
    logic [ADDR_W-1:0]    ld_addr;
    logic                 ld_gnt;
    logic                 ld_done;
    logic [BLOCK_W-1:0]   ld_data;
    logic                 st_req;
    logic [ADDR_W-1:0]    st_addr;
    logic [BLOCK_W-1:0]   st_data;
    logic                 st_gnt;
    logic                 st_done;
    logic [INDEX_W-1:0]   cache_index;
    logic [TAG_W-1:0]     cache_tag;
    logic                 cache_rd_en;
    logic                 cache_wr_en;
    logic [BLOCK_W-1:0]   cache_wr_data;
    logic                 cache_hit;
    logic                 cache_miss;
    logic                 cache_dirty;
    logic [TAG_W-1:0]     victim_tag;
    logic [BLOCK_W-1:0]   cache_rdata;
    logic [1:0]           mem_command;
    logic [ADDR_W-1:0]    mem_addr;
    logic [MEM_TAG_W-1:0] mem_response;
    logic [MEM_TAG_W-1:0] mem_tag;

    always #5 clock = ~clock;

    dcache_controller #(
        .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .INDEX_W(INDEX_W), .MEM_TAG_W(MEM_TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_gnt(st_gnt), .st_done(st_done),
        .cache_index(cache_index), .cache_tag(cache_tag), .cache_rd_en(cache_rd_en),
        .cache_wr_en(cache_wr_en), .cache_wr_data(cache_wr_data), .cache_hit(cache_hit),
        .cache_miss(cache_miss), .cache_dirty(cache_dirty), .victim_tag(victim_tag),
        .cache_rdata(cache_rdata), .mem_command(mem_command), .mem_addr(mem_addr),
        .mem_response(mem_response), .mem_tag(mem_tag)
    );

    // dcache_mem stand-in: answers a probe according to tb_hit / tb_dirty.
    logic             tb_hit;
    logic             tb_dirty;
    logic [TAG_W-1:0] tb_victim;
    logic             probe;
    assign probe       = cache_rd_en | cache_wr_en;
    assign cache_hit   = probe & tb_hit;
    assign cache_miss  = probe & ~tb_hit;
    assign cache_dirty = probe & ~tb_hit & tb_dirty;
    assign victim_tag  = tb_victim;

    logic any_out;
    assign any_out = |{ld_gnt, ld_done, ld_data, st_gnt, st_done, cache_index, cache_tag,
                       cache_rd_en, cache_wr_en, cache_wr_data, mem_command, mem_addr};

    typedef struct {
        bit                 is_store;
        logic [BLOCK_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input bit is_store, input logic [BLOCK_W-1:0] data);
        exp_t e;
        e.is_store = is_store;
        e.data     = data;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation whenever the DUT reports a completion.
    task automatic check_done(input string tag);
        exp_t e;
        if (ld_done || st_done) begin
            chk({tag, "_single_done"}, 64'(ld_done & st_done), 64'd0);
            chk({tag, "_done_expected"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_done_kind"}, 64'(st_done), 64'(e.is_store));
                if (!e.is_store) begin
                    chk({tag, "_ld_data"}, 64'(ld_data), 64'(e.data));
                end
            end
        end
    endtask

    // Drops requests after the accept edge and waits (bounded) for a done.
    task automatic wait_done(input string tag, input int budget, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= budget && !seen; i++) begin
            cyc();
            ld_req = 1'b0; st_req = 1'b0; mem_response = '0; mem_tag = '0;
            #1;
            if (ld_done || st_done) begin
                seen = 1'b1;
                lat  = i;
            end
            check_done(tag);
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic grant_one(input string tag, input bit is_store, input logic [63:0] addr,
                             input logic [63:0] data, input logic [63:0] rdata_exp);
        cyc();
        if (is_store) begin
            st_req = 1'b1; st_addr = addr; st_data = data;
        end else begin
            ld_req = 1'b1; ld_addr = addr;
        end
        #1;
        chk({tag, "_gnt"}, 64'(is_store ? st_gnt : ld_gnt), 64'd1);
        chk({tag, "_other_gnt"}, 64'(is_store ? ld_gnt : st_gnt), 64'd0);
        push_exp(is_store, rdata_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr;
        bit want_st;

        reset = 1'b0; ld_req = 1'b0; ld_addr = '0; st_req = 1'b0; st_addr = '0; st_data = '0;
        cache_rdata = '0; mem_response = '0; mem_tag = '0;
        tb_hit = 1'b0; tb_dirty = 1'b0; tb_victim = '0;

        // Reset: a pending load must not be granted, all outputs quiet.
        cyc(); ld_req = 1'b1; ld_addr = 64'h40; #1;
        chk("rst_ld_gnt", 64'(ld_gnt), 64'd0);
        cyc(); #1;
        chk("rst_outputs_zero", 64'(any_out), 64'd0);
        cyc(); reset = 1'b1; ld_req = 1'b0; #1;

        // Load hit at 0x100: index 0, tag 1, done two cycles after grant.
        tb_hit = 1'b1; cache_rdata = 64'h1111_2222_3333_4444;
        grant_one("hit_ld", 1'b0, 64'h100, 64'h0, 64'h1111_2222_3333_4444);
        cyc(); ld_req = 1'b0; #1;
        chk("hit_rd_en", 64'(cache_rd_en), 64'd1);
        chk("hit_wr_en", 64'(cache_wr_en), 64'd0);
        chk("hit_index", 64'(cache_index), 64'd0);
        chk("hit_tag", 64'(cache_tag), 64'd1);
        wait_done("hit_ld", 4, 1);

        // Clean load miss at 0x208: two bus rejects, issue tag 5, stray tag 3.
        tb_hit = 1'b0; tb_dirty = 1'b0; cache_rdata = 64'h5555_6666_7777_8888;
        grant_one("miss_ld", 1'b0, 64'h208, 64'h0, 64'h5555_6666_7777_8888);
        cyc(); ld_req = 1'b0; #1;
        chk("miss_index", 64'(cache_index), 64'd1);
        chk("miss_tag", 64'(cache_tag), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_response = (i == 2) ? 4'd5 : 4'd0; #1;
            chk("refill_cmd", 64'(mem_command), 64'd1);
            chk("refill_addr", 64'(mem_addr), 64'h208);
        end
        cyc(); mem_response = '0; #1;
        chk("wait_cmd", 64'(mem_command), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(); mem_tag = (i == 4) ? 4'd3 : 4'd0; #1;
            chk("wait_no_done", 64'(ld_done), 64'd0);
        end
        cyc(); mem_tag = 4'd5; #1;
        chk("wait_match_no_done_yet", 64'(ld_done), 64'd0);
        wait_done("miss_ld", 4, 1);

        // Dirty store miss at 0x308 (index 1), victim tag 7 -> writeback to 0x708.
        tb_dirty = 1'b1; tb_victim = 56'h7;
        grant_one("dirty_st", 1'b1, 64'h308, 64'hCAFE_F00D, 64'h0);
        cyc(); st_req = 1'b0; #1;
        chk("dirty_wr_en", 64'(cache_wr_en), 64'd1);
        chk("dirty_rd_en", 64'(cache_rd_en), 64'd0);
        chk("dirty_wr_data", 64'(cache_wr_data), 64'hCAFE_F00D);
        cyc(); mem_response = 4'd0; #1;
        chk("wb_cmd", 64'(mem_command), 64'd2);
        chk("wb_addr", 64'(mem_addr), 64'h708);
        cyc(); mem_response = 4'd3; #1;
        chk("wb_cmd_retry", 64'(mem_command), 64'd2);
        chk("wb_addr_retry", 64'(mem_addr), 64'h708);
        cyc(); mem_response = 4'd0; tb_dirty = 1'b0; #1;
        chk("reprobe_wr_en", 64'(cache_wr_en), 64'd1);
        chk("reprobe_cmd", 64'(mem_command), 64'd0);
        cyc(); mem_response = 4'd4; #1;
        chk("st_refill_cmd", 64'(mem_command), 64'd1);
        chk("st_refill_addr", 64'(mem_addr), 64'h308);
        cyc(); mem_response = 4'd0; mem_tag = 4'd4; #1;
        chk("st_wait_cmd", 64'(mem_command), 64'd0);
        wait_done("dirty_st", 4, 1);

        // Reset for one cycle in WAIT; the dropped tag then returns.
        cache_rdata = 64'h9999;
        grant_one("rst_ld", 1'b0, 64'h410, 64'h0, 64'h9999);
        cyc(); ld_req = 1'b0; #1;
        cyc(); mem_response = 4'd9; #1;
        chk("rst_refill_cmd", 64'(mem_command), 64'd1);
        cyc(); mem_response = 4'd0; reset = 1'b0; #1;
        chk("rst_wait_cmd", 64'(mem_command), 64'd0);
        sb.delete();
        cyc(); reset = 1'b1; mem_tag = 4'd9; #1;
        chk("rst_mid_outputs_zero", 64'(any_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_tag = 4'd0; #1;
            chk("rst_no_done", 64'(ld_done | st_done), 64'd0);
            chk("rst_no_cmd", 64'(mem_command), 64'd0);
        end

        // Both ports held: grants alternate ld, st, ld, st from reset.
        tb_hit = 1'b1; cache_rdata = 64'hABCD;
        ld_addr = 64'h100; st_addr = 64'h108; st_data = 64'h77;
        ngr = 0; want_st = 1'b0;
        cyc(); ld_req = 1'b1; st_req = 1'b1; #1;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            if (i > 0) begin
                cyc(); #1;
            end
            check_done("rr");
            if (ld_gnt || st_gnt) begin
                chk("rr_one_gnt", 64'(ld_gnt & st_gnt), 64'd0);
                chk("rr_gnt_vs_done", 64'(ld_done | st_done), 64'd0);
                chk("rr_order", 64'(st_gnt), 64'(want_st));
                push_exp(st_gnt, 64'hABCD);
                want_st = !want_st;
                ngr++;
            end
        end
        chk("rr_grants", 64'(ngr), 64'd4);
        wait_done("rr_last", 4, 2);

        // Store request arriving while a refill is accepted waits for IDLE.
        tb_hit = 1'b0; tb_dirty = 1'b0; cache_rdata = 64'h6666;
        grant_one("t6_ld", 1'b0, 64'h510, 64'h0, 64'h6666);
        cyc(); ld_req = 1'b0; #1;
        cyc(); mem_response = 4'd6; st_req = 1'b1; st_addr = 64'h518; st_data = 64'h1234; #1;
        chk("t6_refill_cmd", 64'(mem_command), 64'd1);
        chk("t6_no_gnt_refill", 64'(st_gnt), 64'd0);
        cyc(); mem_response = 4'd0; #1;
        chk("t6_no_gnt_wait", 64'(st_gnt), 64'd0);
        cyc(); mem_tag = 4'd6; #1;
        chk("t6_no_gnt_wait2", 64'(st_gnt), 64'd0);
        cyc(); mem_tag = 4'd0; #1;
        chk("t6_ld_done", 64'(ld_done), 64'd1);
        chk("t6_no_gnt_resp", 64'(st_gnt), 64'd0);
        check_done("t6_ld");
        cyc(); #1;
        chk("t6_st_gnt", 64'(st_gnt), 64'd1);
        push_exp(1'b1, 64'h0);
        tb_hit = 1'b1;
        wait_done("t6_st", 4, 2);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
